// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, whole-matrix snapshot
// debounce, one-cycle strobe per accepted single-key press.
module keypad_scanner #(
    parameter int SCANDIV = 50000,
    parameter int DBSCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCANDIV);
    localparam int SW = $clog2(DBSCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCANDIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DBSCANS);

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    ci;
    logic [15:0]   snap;
    logic [15:0]   prev;
    logic          scan_done;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_next;
    state_t        state;
    state_t        state_next;
    logic [3:0]    code_next;
    logic          valid_next;
    logic [4:0]    n_set;
    logic [3:0]    k_idx;
    logic          is_none;
    logic          is_single;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Snapshot bit {ci,r} holds row r as seen while column ci was driven.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell     <= '0;
            ci        <= 2'd0;
            snap      <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (dwell == DWELL_LAST) begin
                dwell                  <= '0;
                ci                     <= ci + 2'd1;
                snap[{ci, 2'b00} +: 4] <= ~row_sync;
                scan_done              <= (ci == 2'd3);
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign col = ~(4'b0001 << ci);

    always_comb begin
        n_set = '0;
        k_idx = '0;
        for (int b = 0; b < 16; b++) begin
            if (snap[b]) begin
                n_set = n_set + 5'd1;
                k_idx = {b[1:0], b[3:2]};
            end
        end
        is_none   = (n_set == 5'd0);
        is_single = (n_set == 5'd1);
    end

    always_comb begin
        stable_next = SW'(1);
        if (snap == prev) begin
            if (stable == STABLE_MAX) stable_next = stable;
            else                      stable_next = stable + SW'(1);
        end
    end

    always_comb begin
        state_next = state;
        code_next  = key_code;
        valid_next = 1'b0;
        if (scan_done) begin
            unique case (state)
                RELEASED: begin
                    if (is_single && stable_next == STABLE_MAX) begin
                        state_next = HELD;
                        code_next  = k_idx;
                        valid_next = 1'b1;
                    end
                end
                HELD: begin
                    if (is_none && stable_next == STABLE_MAX)
                        state_next = RELEASED;
                end
                default: state_next = RELEASED;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RELEASED;
            prev      <= '0;
            stable    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            key_code  <= code_next;
            key_valid <= valid_next;
            if (scan_done) begin
                stable <= stable_next;
                prev   <= snap;
            end
        end
    end

    assign key_held = (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model
// (pressed[row*4+col] shorts that row low while its column is driven).
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int vectors;
    int miscompares;
    int cyc;
    int c0;
    int pulses;
    int last_pulse;

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K15 = 16'h8000;

    keypad_scanner #(
        .SCANDIV(8),
        .DBSCANS(3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (col[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (pressed[r*4+c]) row[r] = 1'b0;
    end

    initial begin
        pulses     = 0;
        last_pulse = -1;
    end
    always @(negedge clock)
        if (key_valid === 1'b1) begin
            pulses     = pulses + 1;
            last_pulse = cyc;
        end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle t is the t-th clock period after reset was last released.
    task automatic at_cycle(input int t);
        @(negedge clock);
        while (cyc < c0 + t) @(negedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        c0          = 0;
        reset       = 1'b1;
        pressed     = '0;

        // 1: reset values and idle column rotation
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_col", col, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_code", key_code, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        c0 = cyc;
        at_cycle(0);   chk("col_c0", col, 4'b1110);
        at_cycle(7);   chk("col_c7", col, 4'b1110);
        at_cycle(8);   chk("col_c8", col, 4'b1101);
        at_cycle(16);  chk("col_c16", col, 4'b1011);
        at_cycle(24);  chk("col_c24", col, 4'b0111);
        at_cycle(31);  chk("col_c31", col, 4'b0111);
        at_cycle(32);  chk("col_wrap", col, 4'b1110);
        at_cycle(128);
        chk("idle_pulses", pulses, 0);
        chk("idle_held", key_held, 0);

        // 2: key 9 held from reset
        pressed = K9;
        reset   = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        c0 = cyc;
        at_cycle(96);
        chk("k9_early_valid", key_valid, 0);
        chk("k9_early_held", key_held, 0);
        at_cycle(97);
        chk("k9_valid", key_valid, 1);
        chk("k9_code", key_code, 9);
        chk("k9_held", key_held, 1);
        at_cycle(98);
        chk("k9_strobe_len", key_valid, 0);
        chk("k9_latency", last_pulse - c0, 97);
        at_cycle(256);
        chk("k9_no_repeat", pulses, 1);
        chk("k9_still_held", key_held, 1);

        // 3: release, then bounce for 10 scans, then steady press
        pressed = '0;
        at_cycle(352); chk("rel_pre", key_held, 1);
        at_cycle(353); chk("rel_done", key_held, 0);
        for (int m = 12; m < 22; m++) begin
            at_cycle(32 * m);
            pressed = (m % 2 == 0) ? K9 : 16'h0000;
        end
        at_cycle(32 * 22);
        pressed = K9;
        at_cycle(800);
        chk("bounce_pulses", pulses, 1);
        chk("bounce_valid", key_valid, 0);
        at_cycle(801);
        chk("bounce_press", key_valid, 1);
        chk("bounce_code", key_code, 9);
        at_cycle(802);
        chk("bounce_strobe_len", key_valid, 0);

        // 4: two keys together, then release one
        at_cycle(32 * 26);
        pressed = '0;
        at_cycle(929);
        chk("s4_released", key_held, 0);
        at_cycle(32 * 30);
        pressed = K9 | K0;
        at_cycle(32 * 38);
        chk("multi_pulses", pulses, 2);
        chk("multi_held", key_held, 0);
        pressed = K9;
        at_cycle(1312); chk("multi_early", key_valid, 0);
        at_cycle(1313);
        chk("multi_resolve", key_valid, 1);
        chk("multi_code", key_code, 9);
        chk("multi_held2", key_held, 1);

        // 5: no rollover from 5 to 6
        at_cycle(32 * 42);
        pressed = '0;
        at_cycle(1441);
        chk("s5_released", key_held, 0);
        at_cycle(32 * 46);
        pressed = K5;
        at_cycle(1569);
        chk("k5_valid", key_valid, 1);
        chk("k5_code", key_code, 5);
        at_cycle(32 * 50);
        pressed = K5 | K6;
        at_cycle(32 * 54);
        chk("k56_pulses", pulses, 4);
        chk("k56_held", key_held, 1);
        pressed = K6;
        at_cycle(32 * 58);
        chk("k6_only_pulses", pulses, 4);
        chk("k6_only_code", key_code, 5);
        chk("k6_only_held", key_held, 1);
        pressed = '0;
        at_cycle(1952); chk("k5_rel_pre", key_held, 1);
        at_cycle(1953); chk("k5_rel", key_held, 0);
        at_cycle(32 * 62);
        pressed = K6;
        at_cycle(2081);
        chk("k6_valid", key_valid, 1);
        chk("k6_code", key_code, 6);
        chk("k6_pulses", pulses, 5);

        // 6: reset while key 15 held
        at_cycle(32 * 66);
        pressed = '0;
        at_cycle(2209);
        chk("s6_released", key_held, 0);
        at_cycle(32 * 70);
        pressed = K15;
        at_cycle(2337);
        chk("k15_valid", key_valid, 1);
        chk("k15_code", key_code, 15);
        at_cycle(2400);
        chk("k15_held_pre", key_held, 1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        c0 = cyc;
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_code", key_code, 0);
        at_cycle(96);
        chk("k15_re_early", key_valid, 0);
        chk("k15_re_held_early", key_held, 0);
        at_cycle(97);
        chk("k15_re_valid", key_valid, 1);
        chk("k15_re_code", key_code, 15);
        chk("k15_re_held", key_held, 1);
        chk("k15_re_pulses", pulses, 7);
        at_cycle(98);
        chk("k15_re_strobe_len", key_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
